// File: rtl/baser_257b_pkg.sv
// Shared constants and pure helpers for the 64b/66b -> 256b/257b transcoder:
// block sanitising, transcoding and scrambler parameters.
package baser_257b_pkg;

  localparam int DATA_W = 64;
  localparam int BLK_W  = DATA_W + 2;
  localparam int TC_W   = 4 * DATA_W + 1;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam logic [7:0]       ERR_TYPE    = 8'h1E;
  localparam logic [BLK_W-1:0] ERROR_BLOCK = {{8{7'h1E}}, ERR_TYPE, SH_CTRL};

  // 1 + x^39 + x^58: taps are the 39th and 58th most recent output bits
  localparam int               SCR_W     = 58;
  localparam int               SCR_TAP_A = 38;
  localparam int               SCR_TAP_B = 57;
  localparam logic [SCR_W-1:0] SCR_SEED  = '1;

  typedef logic [3:0][BLK_W-1:0] group_t;

  function automatic logic type_ok(input logic [7:0] t);
    case (t)
      8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
      8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic blk_bad(input logic [BLK_W-1:0] b);
    return !((b[1:0] == SH_DATA) || ((b[1:0] == SH_CTRL) && type_ok(b[9:2])));
  endfunction

  function automatic logic [BLK_W-1:0] sanitise(input logic [BLK_W-1:0] b);
    return blk_bad(b) ? ERROR_BLOCK : b;
  endfunction

  // Blocks are already sanitised, so any non-data header is a legal control block.
  function automatic logic [TC_W-1:0] transcode(input group_t g);
    logic [TC_W-1:0] tc;
    logic [3:0]      flags;
    logic            found;
    int              pos;
    tc    = '0;
    found = 1'b0;
    pos   = 9;
    for (int i = 0; i < 4; i++) flags[i] = (g[i][1:0] == SH_DATA);
    if (&flags) begin
      tc = {g[3][BLK_W-1:2], g[2][BLK_W-1:2], g[1][BLK_W-1:2], g[0][BLK_W-1:2], 1'b1};
    end else begin
      tc[4:1] = flags;
      for (int i = 0; i < 4; i++) begin
        if (!flags[i] && !found) begin
          tc[8:5]         = g[i][9:6];
          tc[pos +: 56]   = g[i][BLK_W-1:10];
          pos             = pos + 56;
          found           = 1'b1;
        end else begin
          tc[pos +: DATA_W] = g[i][BLK_W-1:2];
          pos               = pos + DATA_W;
        end
      end
    end
    return tc;
  endfunction

endpackage

// File: rtl/baser_257b_scrambler.sv
// Self-synchronous 1+x^39+x^58 scrambler over a 256-bit word, LSB first;
// output is combinational, state advances only on i_load.
module baser_257b_scrambler
  import baser_257b_pkg::*;
(
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [255:0] i_data,
  output logic [255:0] o_data
);

  logic [SCR_W-1:0] state;
  logic [SCR_W-1:0] state_nxt;

  always_comb begin
    logic b;
    state_nxt = state;
    o_data    = '0;
    for (int i = 0; i < 256; i++) begin
      b         = i_data[i] ^ state_nxt[SCR_TAP_A] ^ state_nxt[SCR_TAP_B];
      o_data[i] = b;
      state_nxt = {state_nxt[SCR_W-2:0], b};
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)    state <= SCR_SEED;
    else if (i_load) state <= state_nxt;
  end

endmodule

// File: rtl/baser_257b_transcoder.sv
// Packs four 66b blocks into one 257b block; one-cycle output register with valid/ready.
// Define BASER_257B_SCRAMBLER_EN to scramble o_tc[256:1] before it is registered.
module baser_257b_transcoder
  import baser_257b_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BLK_WIDTH  = DATA_WIDTH + 2,
  parameter int TC_WIDTH   = 4 * DATA_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [BLK_WIDTH-1:0] i_block,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [TC_WIDTH-1:0]  o_tc,
  output logic [31:0]          o_err_count
);

  logic [1:0]                cnt;
  logic [2:0][BLK_WIDTH-1:0] hold;
  logic [BLK_WIDTH-1:0]      san;
  logic                      bad;
  logic                      accept;
  logic                      out_load;
  logic [TC_WIDTH-1:0]       tc_plain;
  logic [TC_WIDTH-1:0]       tc_next;
  logic [4*DATA_WIDTH-1:0]   tc_body;

  // Only the closing block of a group needs the output register to be free.
  assign o_ready  = !((cnt == 2'd3) && o_valid && !i_ready);
  assign accept   = i_valid && o_ready;
  assign out_load = accept && (cnt == 2'd3);

  assign bad      = blk_bad(i_block);
  assign san      = sanitise(i_block);
  assign tc_plain = transcode({san, hold[2], hold[1], hold[0]});

`ifdef BASER_257B_SCRAMBLER_EN
  baser_257b_scrambler u_scrambler (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (out_load),
    .i_data  (tc_plain[TC_WIDTH-1:1]),
    .o_data  (tc_body)
  );
`else
  assign tc_body = tc_plain[TC_WIDTH-1:1];
`endif

  assign tc_next = {tc_body, tc_plain[0]};

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= 2'd0;
      hold        <= '0;
      o_valid     <= 1'b0;
      o_tc        <= '0;
      o_err_count <= '0;
    end else begin
      if (accept) begin
        cnt <= cnt + 2'd1;
        if (cnt != 2'd3) hold[cnt] <= san;
        if (bad && (o_err_count != 32'hFFFF_FFFF)) o_err_count <= o_err_count + 32'd1;
      end
      if (out_load) begin
        o_valid <= 1'b1;
        o_tc    <= tc_next;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
